bit_destuff: RTL

Receive-side CAN 2.0 bit destuffer sitting between the bit-timing/sample stage and the CRC calculator. It consumes one sampled bus bit per `bit_valid` strobe, detects SOF, and removes stuff bits inserted after every five consecutive equal bits. It forwards only data bits, including SOF, to the CRC calculator and frame decoder via `dout`/`dout_valid`. It flags stuff errors when a sixth equal bit appears where a stuff bit is required.

---
 rtl/bit_destuff_if.sv | 64 ++++++
 rtl/bit_destuff.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bit_destuff_if.sv
// -----------------------------------------------------------------------------
// bit_destuff_if
//
// Bundle of the sample-side inputs and destuffed outputs of bit_destuff.
//
// Handshake: there is no backpressure. The frame controller places a sampled
// bus bit on din and raises bit_valid for exactly one clk cycle per nominal bit
// time; the sample is consumed on that rising edge. Every result pulse
// (dout_valid / stuff_drop / stuff_err) is a single-cycle strobe registered on
// the edge that consumed the sample, so the consumer must act on it in the
// cycle it is high. stuff_en is a level, not a strobe.
//
// Signals:
//   din         master->slave  sampled bus bit (0 dominant, 1 recessive)
//   bit_valid   master->slave  one-cycle strobe qualifying din
//   stuff_en    master->slave  stuffed region may be active; low forces IDLE
//   dout        slave->master  destuffed data bit, held between strobes
//   dout_valid  slave->master  one-cycle strobe qualifying dout
//   stuff_drop  slave->master  one-cycle pulse: stuff bit discarded
//   stuff_err   slave->master  one-cycle pulse: stuff rule violated
//   busy        slave->master  state machine is not IDLE
//   stuff_cnt   slave->master  stuff bits removed in current/last frame
//   dbg_state   slave->master  raw FSM state encoding for observation
// -----------------------------------------------------------------------------
interface bit_destuff_if;
    logic       din;
    logic       bit_valid;
    logic       stuff_en;
    logic       dout;
    logic       dout_valid;
    logic       stuff_drop;
    logic       stuff_err;
    logic       busy;
    logic [7:0] stuff_cnt;
    logic [1:0] dbg_state;

    // Frame controller / bit sampler side.
    modport master (
        output din,
        output bit_valid,
        output stuff_en,
        input  dout,
        input  dout_valid,
        input  stuff_drop,
        input  stuff_err,
        input  busy,
        input  stuff_cnt,
        input  dbg_state
    );

    // Destuffer side.
    modport slave (
        input  din,
        input  bit_valid,
        input  stuff_en,
        output dout,
        output dout_valid,
        output stuff_drop,
        output stuff_err,
        output busy,
        output stuff_cnt,
        output dbg_state
    );
endinterface

// File: rtl/bit_destuff.sv
// -----------------------------------------------------------------------------
// bit_destuff
//
// Receive-side CAN 2.0 bit destuffer. Consumes one sampled bus bit per
// bit_valid strobe, detects SOF (first dominant sample while idle), removes the
// stuff bit that follows every run of five equal bits, and forwards the
// remaining data bits (SOF included) on dout/dout_valid. A sixth equal bit at a
// stuff position raises stuff_err and parks the FSM in ERR until stuff_en
// drops.
//
// Ports:
//   clk   input   system clock, all logic on the rising edge
//   rst   input   synchronous active-high reset
//   bus   slave   bit_destuff_if: din/bit_valid/stuff_en in,
//                 dout/dout_valid/stuff_drop/stuff_err/busy/stuff_cnt/dbg_state out
//
// Build option:
//   DESTUFF_STATS_EN  when defined, stuff_cnt counts discarded stuff bits per
//                     frame (cleared on SOF, saturating at 255, held after the
//                     frame). When undefined, stuff_cnt is constant zero.
// -----------------------------------------------------------------------------
module bit_destuff (
    input  logic         clk,
    input  logic         rst,
    bit_destuff_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Run length at which the next sample must be a stuff bit.
    localparam logic [2:0] STUFF_RUN = 3'd5;

    // State and bookkeeping registers.
    state_t     r_state;
    logic       r_last_bit;
    logic [2:0] r_run_len;

    // Registered outputs.
    logic       r_dout;
    logic       r_dout_valid;
    logic       r_stuff_drop;
    logic       r_stuff_err;

    // Next-state values from the combinational process.
    state_t     w_state_nxt;
    logic       w_last_bit_nxt;
    logic [2:0] w_run_len_nxt;
    logic       w_dout_nxt;
    logic       w_dout_valid_nxt;
    logic       w_stuff_drop_nxt;
    logic       w_stuff_err_nxt;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_last_bit_nxt   = r_last_bit;
        w_run_len_nxt    = r_run_len;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = 1'b0;
        w_stuff_drop_nxt = 1'b0;
        w_stuff_err_nxt  = 1'b0;

        if (!bus.stuff_en) begin
            // Leaving the stuffed region wins over any same-cycle sample,
            // which is dropped without producing a pulse.
            w_state_nxt    = ST_IDLE;
            w_run_len_nxt  = 3'd0;
            w_last_bit_nxt = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Only a dominant sample is SOF; recessive idle bits are
                    // bus-idle and are ignored.
                    if (bus.bit_valid && !bus.din) begin
                        w_dout_nxt       = 1'b0;
                        w_dout_valid_nxt = 1'b1;
                        w_last_bit_nxt   = 1'b0;
                        w_run_len_nxt    = 3'd1;
                        w_state_nxt      = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (bus.bit_valid) begin
                        if (r_run_len == STUFF_RUN) begin
                            if (bus.din != r_last_bit) begin
                                // Correct stuff bit: discard it, but it still
                                // counts as the first bit of the next run.
                                w_stuff_drop_nxt = 1'b1;
                                w_last_bit_nxt   = bus.din;
                                w_run_len_nxt    = 3'd1;
                            end else begin
                                w_stuff_err_nxt  = 1'b1;
                                w_state_nxt      = ST_ERR;
                            end
                        end else begin
                            w_dout_nxt       = bus.din;
                            w_dout_valid_nxt = 1'b1;
                            if (bus.din == r_last_bit) begin
                                w_run_len_nxt  = r_run_len + 3'd1;
                            end else begin
                                w_run_len_nxt  = 3'd1;
                                w_last_bit_nxt = bus.din;
                            end
                        end
                    end
                end

                ST_ERR: begin
                    // Frame is dead; wait for stuff_en to drop.
                end

                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_run_len_nxt  = 3'd0;
                    w_last_bit_nxt = 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_bit   <= 1'b1;
            r_run_len    <= 3'd0;
            r_dout       <= 1'b1;
            r_dout_valid <= 1'b0;
            r_stuff_drop <= 1'b0;
            r_stuff_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_bit   <= w_last_bit_nxt;
            r_run_len    <= w_run_len_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_stuff_drop <= w_stuff_drop_nxt;
            r_stuff_err  <= w_stuff_err_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Optional per-frame stuff-bit statistics
    // -------------------------------------------------------------------------
`ifdef DESTUFF_STATS_EN
    logic [7:0] r_stuff_cnt;
    logic       w_sof;

    // SOF is the only way a data pulse is produced from IDLE.
    assign w_sof = w_dout_valid_nxt && (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stuff_cnt <= 8'd0;
        end else if (w_sof) begin
            r_stuff_cnt <= 8'd0;
        end else if (w_stuff_drop_nxt && (r_stuff_cnt != 8'hFF)) begin
            r_stuff_cnt <= r_stuff_cnt + 8'd1;
        end
    end

    assign bus.stuff_cnt = r_stuff_cnt;
`else
    assign bus.stuff_cnt = 8'd0;
`endif

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.stuff_drop = r_stuff_drop;
    assign bus.stuff_err  = r_stuff_err;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.dbg_state  = r_state;

endmodule
